// File: rtl/note_frame_enable.sv
// -----------------------------------------------------------------------------
// note_frame_enable
//
// Captures a multi-voice note frame from the MCU SPI receiver when the SPI
// chip-enable (ce) deasserts, and presents it to the tone generators with a
// one-cycle start pulse. A frame that arrives while the player is busy is held
// in a one-deep pending buffer. If a buffered frame is replaced or discarded
// before it is played, a sticky overrun flag is raised.
//
// Parameters:
//   VOICES      number of note channels in a frame
//   NOTE_W      bits per voice note code
//   ACK_TIMEOUT cycles to wait for makingMusic after start before giving up
//
// Ports:
//   clk                 system clock
//   reset               synchronous active-high reset
//   ce                  MCU SPI chip enable (async, idle high; fall = frame done)
//   newFlattenedMCUout  frame from SPI shift register, stable while ce low
//   makingMusic         high while the player is sounding the current frame
//   clearOverrun        one-cycle clear of the overrun flag
//   flattenedMCUout     frame presented to tone generators
//   start               one-cycle pulse: new frame valid on flattenedMCUout
//   voiceActive         bit i high when voice i note field is nonzero
//   pending             a frame is buffered awaiting playback
//   overrun             sticky: a buffered frame was discarded unplayed
// -----------------------------------------------------------------------------
module note_frame_enable #(
  parameter int VOICES      = 4,
  parameter int NOTE_W      = 10,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [VOICES*NOTE_W-1:0] newFlattenedMCUout,
  input  logic                     makingMusic,
  input  logic                     clearOverrun,
  output logic [VOICES*NOTE_W-1:0] flattenedMCUout,
  output logic                     start,
  output logic [VOICES-1:0]        voiceActive,
  output logic                     pending,
  output logic                     overrun
);

  localparam int FRAME_W = VOICES * NOTE_W;
  localparam int CNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_WAIT = 2'd1,
    PLAYING  = 2'd2
  } state_t;

  // Per-voice activity: a voice is active when any bit of its note is set.
  function automatic logic [VOICES-1:0] active_of(input logic [FRAME_W-1:0] f);
    logic [VOICES-1:0] a;
    a = {VOICES{1'b0}};
    for (int v = 0; v < VOICES; v++) begin
      a[v] = |f[v*NOTE_W +: NOTE_W];
    end
    return a;
  endfunction

  logic               ce_s1_q, ce_s2_q, ce_prev_q;
  logic [1:0]         vld_q;
  logic               arm_q;
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] frame_q;
  logic [VOICES-1:0]  active_q;
  logic               start_q;
  logic [FRAME_W-1:0] pend_buf_q;
  logic               pending_q;
  logic               overrun_q;

  logic               fall_s;
  logic [VOICES-1:0]  new_active_d;
  logic [VOICES-1:0]  pend_active_d;

  // The synchroniser resets to 1, so if ce is held low across reset the
  // chain would still show a synthetic high->low edge on release. arm_q only
  // opens once a genuinely sampled high ce has reached ce_s2_q (vld_q tracks
  // when the chain holds real samples), so a frame cut short by reset is
  // never loaded.
  assign fall_s        = arm_q & ce_prev_q & ~ce_s2_q;
  assign new_active_d  = active_of(newFlattenedMCUout);
  assign pend_active_d = active_of(pend_buf_q);

  assign flattenedMCUout = frame_q;
  assign voiceActive     = active_q;
  assign start           = start_q;
  assign pending         = pending_q;
  assign overrun         = overrun_q;

  // ce synchroniser, edge-history flop and arming logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_s1_q   <= 1'b1;
      ce_s2_q   <= 1'b1;
      ce_prev_q <= 1'b1;
      vld_q     <= 2'b00;
      arm_q     <= 1'b0;
    end else begin
      ce_s1_q   <= ce;
      ce_s2_q   <= ce_s1_q;
      ce_prev_q <= ce_s2_q;
      vld_q     <= {vld_q[0], 1'b1};
      arm_q     <= arm_q | (vld_q[1] & ce_s2_q);
    end
  end

  // Frame hand-off FSM with pending buffer, ack timeout and overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      frame_q    <= {FRAME_W{1'b0}};
      active_q   <= {VOICES{1'b0}};
      start_q    <= 1'b0;
      pend_buf_q <= {FRAME_W{1'b0}};
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      // Any overrun set below is a later assignment, so set beats clear.
      if (clearOverrun) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          cnt_q <= {CNT_W{1'b0}};
          if (fall_s) begin
            frame_q  <= newFlattenedMCUout;
            active_q <= new_active_d;
            start_q  <= 1'b1;
            state_q  <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (makingMusic) begin
            state_q <= PLAYING;
            if (fall_s) begin
              pend_buf_q <= newFlattenedMCUout;
              pending_q  <= 1'b1;
              if (pending_q) begin
                overrun_q <= 1'b1;
              end
            end
          end else if (cnt_q == CNT_LAST) begin
            // Player never acknowledged: offer the next frame if there is one,
            // otherwise give up and keep the current frame on the outputs.
            cnt_q <= {CNT_W{1'b0}};
            if (fall_s) begin
              frame_q   <= newFlattenedMCUout;
              active_q  <= new_active_d;
              start_q   <= 1'b1;
              pending_q <= 1'b0;
              if (pending_q) begin
                overrun_q <= 1'b1;
              end
            end else if (pending_q) begin
              frame_q   <= pend_buf_q;
              active_q  <= pend_active_d;
              start_q   <= 1'b1;
              pending_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (fall_s) begin
            pend_buf_q <= newFlattenedMCUout;
            pending_q  <= 1'b1;
            if (pending_q) begin
              overrun_q <= 1'b1;
            end
          end
        end
        PLAYING: begin
          cnt_q <= {CNT_W{1'b0}};
          if (!makingMusic) begin
            if (fall_s) begin
              // A fresh frame supersedes whatever was buffered.
              frame_q   <= newFlattenedMCUout;
              active_q  <= new_active_d;
              start_q   <= 1'b1;
              pending_q <= 1'b0;
              state_q   <= ACK_WAIT;
              if (pending_q) begin
                overrun_q <= 1'b1;
              end
            end else if (pending_q) begin
              frame_q   <= pend_buf_q;
              active_q  <= pend_active_d;
              start_q   <= 1'b1;
              pending_q <= 1'b0;
              state_q   <= ACK_WAIT;
            end else begin
              state_q <= IDLE;
            end
          end else if (fall_s) begin
            pend_buf_q <= newFlattenedMCUout;
            pending_q  <= 1'b1;
            if (pending_q) begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_frame_enable.sv
// -----------------------------------------------------------------------------
// tb_note_frame_enable
//
// Directed bench for note_frame_enable with ACK_TIMEOUT=8. Inputs change 1 ns
// after each rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_note_frame_enable;

  localparam int VOICES  = 4;
  localparam int NOTE_W  = 10;
  localparam int FRAME_W = VOICES * NOTE_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic [FRAME_W-1:0] newFlattenedMCUout;
  logic               makingMusic;
  logic               clearOverrun;
  logic [FRAME_W-1:0] flattenedMCUout;
  logic               start;
  logic [VOICES-1:0]  voiceActive;
  logic               pending;
  logic               overrun;

  int vectors     = 0;
  int miscompares = 0;
  logic saw_start;

  localparam logic [FRAME_W-1:0] F3  = 40'd3;
  localparam logic [FRAME_W-1:0] F5  = 40'd5;
  localparam logic [FRAME_W-1:0] F12 = 40'd12;
  localparam logic [FRAME_W-1:0] F15 = 40'd15;
  // voice3=0x001, voice2=0, voice1=0x200, voice0=0 -> voiceActive 4'b1010
  localparam logic [FRAME_W-1:0] FMV = {10'h001, 10'h000, 10'h200, 10'h000};

  note_frame_enable #(
    .VOICES(VOICES),
    .NOTE_W(NOTE_W),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ce(ce),
    .newFlattenedMCUout(newFlattenedMCUout),
    .makingMusic(makingMusic),
    .clearOverrun(clearOverrun),
    .flattenedMCUout(flattenedMCUout),
    .start(start),
    .voiceActive(voiceActive),
    .pending(pending),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drop ce with the given frame; returns in the cycle where the synchronised
  // falling edge is visible (the load/capture happens on the next edge).
  task automatic fall_cycle(input logic [FRAME_W-1:0] f);
    newFlattenedMCUout = f;
    ce = 1'b0;
    step(2);
  endtask

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    newFlattenedMCUout = {FRAME_W{1'b0}};
    makingMusic = 1'b0;
    clearOverrun = 1'b0;
    step(2);

    // Reset state
    chk("rst_frame",   64'(flattenedMCUout), 64'd0);
    chk("rst_start",   64'(start),           64'd0);
    chk("rst_active",  64'(voiceActive),     64'd0);
    chk("rst_pending", 64'(pending),         64'd0);
    chk("rst_overrun", 64'(overrun),         64'd0);
    reset = 1'b0;
    step(4);

    // Idle load: frame appears on the third edge after ce low
    fall_cycle(F3);
    chk("idle_pre_start", 64'(start),           64'd0);
    chk("idle_pre_frame", 64'(flattenedMCUout), 64'd0);
    step(1);
    chk("idle_frame",  64'(flattenedMCUout), 64'(F3));
    chk("idle_start",  64'(start),           64'd1);
    chk("idle_active", 64'(voiceActive),     64'h1);
    ce = 1'b1;

    // Ack timeout: eight cycles in ACK_WAIT with makingMusic low, no restart
    saw_start = 1'b0;
    repeat (8) begin
      step(1);
      saw_start = saw_start | start;
    end
    chk("tmo_no_start", 64'(saw_start),       64'd0);
    chk("tmo_frame",    64'(flattenedMCUout), 64'(F3));
    chk("tmo_pending",  64'(pending),         64'd0);
    // Back in IDLE: a fall now loads directly even with makingMusic high
    makingMusic = 1'b1;
    fall_cycle(F5);
    step(1);
    chk("tmo_idle_frame", 64'(flattenedMCUout), 64'(F5));
    chk("tmo_idle_start", 64'(start),           64'd1);
    ce = 1'b1;
    step(3);

    // Deferred load while PLAYING
    fall_cycle(F12);
    step(1);
    chk("def_pending", 64'(pending),         64'd1);
    chk("def_hold",    64'(flattenedMCUout), 64'(F5));
    chk("def_nostart", 64'(start),           64'd0);
    ce = 1'b1;
    step(3);
    makingMusic = 1'b0;
    step(1);
    chk("def_frame",   64'(flattenedMCUout), 64'(F12));
    chk("def_start",   64'(start),           64'd1);
    chk("def_pend0",   64'(pending),         64'd0);
    chk("def_active",  64'(voiceActive),     64'h1);
    makingMusic = 1'b1;
    step(1);
    chk("def_start_once", 64'(start), 64'd0);

    // Overrun: two falls while PLAYING, last one wins
    fall_cycle(F12);
    step(1);
    chk("ovr_pend1", 64'(pending), 64'd1);
    chk("ovr_clean", 64'(overrun), 64'd0);
    ce = 1'b1;
    step(3);
    fall_cycle(F15);
    step(1);
    chk("ovr_pend2", 64'(pending),         64'd1);
    chk("ovr_set",   64'(overrun),         64'd1);
    chk("ovr_hold",  64'(flattenedMCUout), 64'(F12));
    ce = 1'b1;
    step(3);
    makingMusic = 1'b0;
    step(1);
    chk("ovr_frame", 64'(flattenedMCUout), 64'(F15));
    chk("ovr_start", 64'(start),           64'd1);
    makingMusic = 1'b1;
    clearOverrun = 1'b1;
    step(1);
    clearOverrun = 1'b0;
    chk("ovr_clear", 64'(overrun), 64'd0);

    // Simultaneous fall and makingMusic drop with frame 12 pending;
    // clearOverrun in the same cycle must lose to the set
    fall_cycle(F12);
    step(1);
    ce = 1'b1;
    step(3);
    chk("sim_pend_pre", 64'(pending), 64'd1);
    fall_cycle(F15);
    makingMusic = 1'b0;
    clearOverrun = 1'b1;
    step(1);
    clearOverrun = 1'b0;
    ce = 1'b1;
    chk("sim_frame",   64'(flattenedMCUout), 64'(F15));
    chk("sim_start",   64'(start),           64'd1);
    chk("sim_pending", 64'(pending),         64'd0);
    chk("sim_overrun", 64'(overrun),         64'd1);
    step(1);
    chk("sim_single_start", 64'(start), 64'd0);
    clearOverrun = 1'b1;
    step(1);
    clearOverrun = 1'b0;
    chk("sim_clear", 64'(overrun), 64'd0);

    // Multi-voice frame after the timeout returns to IDLE
    step(10);
    fall_cycle(FMV);
    step(1);
    chk("mv_frame",  64'(flattenedMCUout), 64'(FMV));
    chk("mv_active", 64'(voiceActive),     64'hA);
    chk("mv_start",  64'(start),           64'd1);
    makingMusic = 1'b1;
    ce = 1'b1;
    step(3);

    // Reset mid-operation with ce still low
    fall_cycle(F12);
    step(1);
    chk("mid_pend", 64'(pending), 64'd1);
    reset = 1'b1;
    step(1);
    chk("mid_frame",   64'(flattenedMCUout), 64'd0);
    chk("mid_active",  64'(voiceActive),     64'd0);
    chk("mid_pending", 64'(pending),         64'd0);
    chk("mid_overrun", 64'(overrun),         64'd0);
    chk("mid_start",   64'(start),           64'd0);
    reset = 1'b0;
    makingMusic = 1'b0;
    saw_start = 1'b0;
    repeat (6) begin
      step(1);
      saw_start = saw_start | start;
    end
    chk("mid_no_load_start", 64'(saw_start),       64'd0);
    chk("mid_no_load_frame", 64'(flattenedMCUout), 64'd0);
    // Normal loading resumes once ce has been seen high
    ce = 1'b1;
    step(4);
    fall_cycle(F3);
    step(1);
    chk("post_frame", 64'(flattenedMCUout), 64'(F3));
    chk("post_start", 64'(start),           64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_frame_enable.md
Name: note_frame_enable

Overview:
- Parametrised successor to the single-frame enable logic.
- Captures a multi-voice note frame from the MCU SPI receiver when chip-enable (ce) deasserts, then hands it to the tone generators with a one-cycle start pulse.
- Adds ce synchronisation, a one-deep pending buffer for frames that arrive while music is playing, a player-acknowledge timeout, per-voice activity flags and sticky overrun reporting.

Parameters:
VOICES, 4, number of note channels in a frame
NOTE_W, 10, bits per voice note code
ACK_TIMEOUT, 1024, cycles to wait for makingMusic to rise after start before returning to IDLE
FRAME_W, VOICES*NOTE_W (derived, localparam), total frame width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ce  in  1  MCU SPI chip enable, asynchronous, idle high; falling edge marks frame complete
newFlattenedMCUout  in  FRAME_W  frame from SPI shift register, stable while ce low
makingMusic  in  1  high while player is sounding the current frame
clearOverrun  in  1  one-cycle clear of overrun flag
flattenedMCUout  out  FRAME_W  frame presented to tone generators
start  out  1  one-cycle pulse: new frame valid on flattenedMCUout
voiceActive  out  VOICES  bit i = OR of voice i note field (nonzero note)
pending  out  1  a frame is buffered awaiting playback
overrun  out  1  sticky: a buffered frame was discarded unplayed

Behaviour:
- Reset, the only reset: synchronous, active-high, sampled on rising clk edge only.
  - Reset values: flattenedMCUout=0, voiceActive=0, start=0, pending=0, overrun=0, pend_buf=0, state=IDLE, ack counter=0.
  - ce synchroniser flops and ce_prev reset to 1, so no spurious edge after reset.
  - Reset mid-operation drops any pending frame; overrun is not set.
- ce path: 2-flop synchroniser ce_s1 -> ce_s2, then ce_prev <= ce_s2.
  - fall = ce_prev & ~ce_s2.
  - ce low before edge E0 gives fall true in the cycle after E1.
  - newFlattenedMCUout is sampled in the fall cycle.
- Load action: flattenedMCUout and voiceActive update at the next edge (E2 for direct loads). start is high for exactly the following cycle.
  - Direct-load latency: 3 rising edges from ce low to new frame, with start high in that same first cycle.
  - voiceActive is always consistent with flattenedMCUout in the same cycle.
- States:
  - IDLE: on fall -> load, go ACK_WAIT.
  - ACK_WAIT: counter increments each cycle.
    - makingMusic=1 -> PLAYING.
    - Counter reaches ACK_TIMEOUT-1 with makingMusic still 0 -> IDLE; frame outputs hold, no start.
    - On fall: frame goes to pend_buf, pending=1.
  - PLAYING:
    - fall -> pend_buf <= frame, pending=1; if pending was already 1, overwrite and set overrun.
    - makingMusic=0 with pending=1 -> load pend_buf, pending=0, go ACK_WAIT.
    - makingMusic=0 with pending=0 -> IDLE.
- Pending in IDLE: not possible. An ACK_WAIT timeout with pending=1 loads pend_buf immediately, pending=0, restarts ACK_WAIT.
- Simultaneous fall and makingMusic falling in PLAYING:
  - New frame loads directly and start pulses.
  - If pending was 1, the old pend_buf is discarded, pending=0 and overrun=1.
- overrun: cleared by clearOverrun or reset. If a set and clearOverrun coincide, set wins.
- start never asserts on two consecutive cycles. flattenedMCUout changes only on a load action.

Test Plan:
- Idle load: reset, then ce 1->0 with frame=0x00000_00003 (40-bit). Required: flattenedMCUout=3 on 3rd edge after ce low, start high 1 cycle, voiceActive=4'b0001.
- Deferred load: makingMusic=1 in PLAYING, ce fall with frame=12. Required: pending=1, output unchanged. Drop makingMusic: next edge loads 12, start pulses, pending=0, voiceActive=4'b0001.
- Overrun: in PLAYING, two ce falls (frames 12 then 15). Required: pending=1, overrun=1; after makingMusic=0, output=15. Then clearOverrun -> overrun=0.
- Ack timeout: load frame with makingMusic held 0, ACK_TIMEOUT=8. Required: state IDLE after 8 cycles, no second start, output retained.
- Simultaneous event: in PLAYING with pending frame 12, ce fall (frame 15) and makingMusic 1->0 on the same cycle. Required: output=15, single start, pending=0, overrun=1.
- Reset mid-operation: pending=1 in PLAYING, assert reset 1 cycle. Required: all outputs 0, no start on release, and ce held low through reset produces no load.
